// File: rtl/point_overlay_if.sv
// Point-in, scan-in and overlaid-pixel-out bundle for point_overlay.
// The master side (tracker + scan source) drives i_*; the slave (point_overlay) drives o_*.
interface point_overlay_if;
  logic        i_point_valid;
  logic [9:0]  i_pointH;
  logic [9:0]  i_pointV;
  logic        i_frame_start;
  logic        i_scan_valid;
  logic [9:0]  i_scanH;
  logic [9:0]  i_scanV;
  logic [23:0] i_RGB;
  logic [23:0] o_RGB;
  logic        o_valid;
  logic [4:0]  o_trail_count;
  logic        o_tracking;

  modport master (
    output i_point_valid, i_pointH, i_pointV, i_frame_start,
    output i_scan_valid, i_scanH, i_scanV, i_RGB,
    input  o_RGB, o_valid, o_trail_count, o_tracking
  );

  modport slave (
    input  i_point_valid, i_pointH, i_pointV, i_frame_start,
    input  i_scan_valid, i_scanH, i_scanV, i_RGB,
    output o_RGB, o_valid, o_trail_count, o_tracking
  );
endinterface

// File: rtl/point_overlay.sv
// Box outline + history-trail overlay for the tracked point on a 640x480 pixel stream.
// Optional trail ring is built only when POINT_OVERLAY_TRAIL_EN is defined.
module point_overlay #(
  parameter int unsigned TRAIL_DEPTH = 8,
  parameter int unsigned BOX_HALF    = 8,
  parameter int unsigned LOST_FRAMES = 15,
  parameter logic [23:0] BOX_COLOR   = 24'hFF0000,
  parameter logic [23:0] TRAIL_COLOR = 24'h00FF00
) (
  input logic            i_clk,
  input logic            i_rst,
  point_overlay_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_TRACK} state_e;

  localparam logic [10:0] BOX_H    = 11'(BOX_HALF);
  localparam logic [7:0]  LOST_LIM = 8'(LOST_FRAMES);

  state_e      state_q, state_d;
  logic        pend_flag_q, pend_flag_d;
  logic [9:0]  pend_h_q, pend_h_d, pend_v_q, pend_v_d;
  logic [9:0]  cur_h_q, cur_h_d, cur_v_q, cur_v_d;
  logic [7:0]  lost_cnt_q, lost_cnt_d;
  logic        point_ok;
  logic        push;
  logic        clear_trail;

  logic        box_hit;
  logic        trail_hit;
  logic [10:0] box_dh, box_dv;

  logic        s1_valid_q;
  logic [23:0] s1_rgb_q;
  logic        s1_box_q;
  logic        s1_trail_q;
  logic        out_valid_q;
  logic [23:0] out_rgb_q;

  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? $unsigned(-d) : $unsigned(d);
  endfunction

  assign point_ok = bus.i_point_valid && (bus.i_pointH < 10'd640) && (bus.i_pointV < 10'd480);

  // A commit consumes the pending value as it stood before this cycle; a point
  // arriving on the same cycle becomes pending for the following frame.
  always_comb begin
    state_d     = state_q;
    pend_flag_d = pend_flag_q;
    pend_h_d    = pend_h_q;
    pend_v_d    = pend_v_q;
    cur_h_d     = cur_h_q;
    cur_v_d     = cur_v_q;
    lost_cnt_d  = lost_cnt_q;
    push        = 1'b0;
    clear_trail = 1'b0;
    if (bus.i_frame_start) begin
      if (pend_flag_q) begin
        push        = (state_q == ST_TRACK);
        cur_h_d     = pend_h_q;
        cur_v_d     = pend_v_q;
        pend_flag_d = 1'b0;
        lost_cnt_d  = 8'd0;
        state_d     = ST_TRACK;
      end else begin
        if (lost_cnt_q != 8'hFF) begin
          lost_cnt_d = lost_cnt_q + 8'd1;
        end
        if ((state_q == ST_TRACK) && (lost_cnt_d >= LOST_LIM)) begin
          state_d     = ST_IDLE;
          clear_trail = 1'b1;
        end
      end
    end
    if (point_ok) begin
      pend_h_d    = bus.i_pointH;
      pend_v_d    = bus.i_pointV;
      pend_flag_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      pend_flag_q <= 1'b0;
      pend_h_q    <= '0;
      pend_v_q    <= '0;
      cur_h_q     <= '0;
      cur_v_q     <= '0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_flag_q <= pend_flag_d;
      pend_h_q    <= pend_h_d;
      pend_v_q    <= pend_v_d;
      cur_h_q     <= cur_h_d;
      cur_v_q     <= cur_v_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign box_dh  = abs_diff(bus.i_scanH, cur_h_q);
  assign box_dv  = abs_diff(bus.i_scanV, cur_v_q);
  assign box_hit = (state_q == ST_TRACK) &&
                   (((box_dh == BOX_H) && (box_dv <= BOX_H)) ||
                    ((box_dv == BOX_H) && (box_dh <= BOX_H)));

`ifdef POINT_OVERLAY_TRAIL_EN
  localparam int unsigned PTR_W  = (TRAIL_DEPTH > 1) ? $clog2(TRAIL_DEPTH) : 1;
  localparam logic [4:0]  DEPTH5 = 5'(TRAIL_DEPTH);

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [4:0]             count_q, count_d;
  logic [TRAIL_DEPTH-1:0] dot_hit;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_trail) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (count_q != DEPTH5) begin
        count_d = count_q + 5'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries fill from index 0 after IDLE, so index < count marks occupancy
  // both before and after the ring wraps.
  for (genvar gi = 0; gi < int'(TRAIL_DEPTH); gi++) begin : g_entry
    logic [9:0]  h_q, v_q;
    logic [10:0] dh, dv;

    always_ff @(posedge i_clk) begin
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        h_q <= cur_h_q;
        v_q <= cur_v_q;
      end
    end

    assign dh          = abs_diff(bus.i_scanH, h_q);
    assign dv          = abs_diff(bus.i_scanV, v_q);
    assign dot_hit[gi] = (5'(gi) < count_q) && (dh <= 11'd1) && (dv <= 11'd1);
  end

  assign trail_hit         = (state_q == ST_TRACK) && (|dot_hit);
  assign bus.o_trail_count = count_q;
`else
  assign trail_hit         = 1'b0;
  assign bus.o_trail_count = 5'd0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_rgb_q    <= '0;
      s1_box_q    <= 1'b0;
      s1_trail_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
    end else begin
      s1_valid_q  <= bus.i_scan_valid;
      s1_rgb_q    <= bus.i_RGB;
      s1_box_q    <= box_hit;
      s1_trail_q  <= trail_hit;
      out_valid_q <= s1_valid_q;
      out_rgb_q   <= s1_box_q ? BOX_COLOR : (s1_trail_q ? TRAIL_COLOR : s1_rgb_q);
    end
  end

  assign bus.o_RGB      = out_rgb_q;
  assign bus.o_valid    = out_valid_q;
  assign bus.o_tracking = (state_q == ST_TRACK);

endmodule

// File: tb/tb_point_overlay.sv
// Directed bench for point_overlay: a spec-level model (queue trail, integer
// distances) checked every cycle, plus hand-computed literal pixel checks.
module tb_point_overlay;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BH    = 8;
  localparam int unsigned LOST  = 15;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
`ifdef POINT_OVERLAY_TRAIL_EN
  localparam bit TRAIL_ON = 1'b1;
`else
  localparam bit TRAIL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   cmp_en = 1'b0;

  point_overlay_if bus_if ();

  point_overlay #(
    .TRAIL_DEPTH(DEPTH), .BOX_HALF(BH), .LOST_FRAMES(LOST),
    .BOX_COLOR(RED), .TRAIL_COLOR(GREEN)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_if)
  );

  always #20 clk = ~clk;

  typedef struct { int h; int v; } pt_t;
  pt_t m_trail[$];
  bit  m_track = 0, m_pflag = 0;
  int  m_ch = 0, m_cv = 0, m_ph = 0, m_pv = 0, m_lost = 0;
  bit  p_valid = 0, e_valid = 0;
  logic [23:0] p_rgb = '0, e_rgb = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int adist(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [23:0] expect_pix(int h, int v, logic [23:0] bg);
    int dh, dv;
    if (!m_track) return bg;
    dh = adist(h, m_ch);
    dv = adist(v, m_cv);
    if ((dh == int'(BH) && dv <= int'(BH)) || (dv == int'(BH) && dh <= int'(BH))) return RED;
    foreach (m_trail[i])
      if (adist(h, m_trail[i].h) <= 1 && adist(v, m_trail[i].v) <= 1) return GREEN;
    return bg;
  endfunction

  // Reference model: evaluated on each rising edge from the stable inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_track = 0; m_pflag = 0; m_lost = 0; m_trail.delete();
        p_valid = 0; e_valid = 0; p_rgb = '0; e_rgb = '0;
      end else begin
        e_valid = p_valid;
        e_rgb   = p_rgb;
        p_valid = bus_if.i_scan_valid;
        p_rgb   = expect_pix(int'(bus_if.i_scanH), int'(bus_if.i_scanV), bus_if.i_RGB);
        if (bus_if.i_frame_start) begin
          if (m_pflag) begin
            if (m_track && TRAIL_ON) begin
              m_trail.push_front('{h: m_ch, v: m_cv});
              if (m_trail.size() > int'(DEPTH)) void'(m_trail.pop_back());
            end
            m_ch = m_ph; m_cv = m_pv; m_track = 1; m_lost = 0; m_pflag = 0;
          end else begin
            if (m_lost < 255) m_lost++;
            if (m_track && m_lost >= int'(LOST)) begin
              m_track = 0;
              m_trail.delete();
            end
          end
        end
        if (bus_if.i_point_valid && bus_if.i_pointH < 640 && bus_if.i_pointV < 480) begin
          m_ph = int'(bus_if.i_pointH); m_pv = int'(bus_if.i_pointV); m_pflag = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc o_valid", bus_if.o_valid, e_valid);
        if (e_valid) check("cyc o_RGB", bus_if.o_RGB, e_rgb);
        check("cyc o_tracking", bus_if.o_tracking, m_track);
        check("cyc o_trail_count", bus_if.o_trail_count, m_trail.size());
      end
    end
  end

  task automatic drive_point(int h, int v, bit fs);
    @(negedge clk);
    bus_if.i_point_valid = 1'b1;
    bus_if.i_pointH      = 10'(h);
    bus_if.i_pointV      = 10'(v);
    bus_if.i_frame_start = fs;
    @(negedge clk);
    bus_if.i_point_valid = 1'b0;
    bus_if.i_frame_start = 1'b0;
    $display("point (%0d,%0d) frame_start=%0d", h, v, fs);
  endtask

  task automatic frame();
    @(negedge clk);
    bus_if.i_frame_start = 1'b1;
    @(negedge clk);
    bus_if.i_frame_start = 1'b0;
    $display("frame_start tracking=%0d trail=%0d", bus_if.o_tracking, bus_if.o_trail_count);
  endtask

  task automatic scan(string name, int h, int v, logic [23:0] bg, logic [23:0] exp);
    @(negedge clk);
    bus_if.i_scan_valid = 1'b1;
    bus_if.i_scanH      = 10'(h);
    bus_if.i_scanV      = 10'(v);
    bus_if.i_RGB        = bg;
    @(negedge clk);
    bus_if.i_scan_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, " valid"}, bus_if.o_valid, 1'b1);
    check(name, bus_if.o_RGB, exp);
    $display("scan %s (%0d,%0d) in=%06h out=%06h expect=%06h", name, h, v, bg, bus_if.o_RGB, exp);
  endtask

  initial begin
    bus_if.i_point_valid = 0; bus_if.i_pointH = 0; bus_if.i_pointV = 0;
    bus_if.i_frame_start = 0; bus_if.i_scan_valid = 0;
    bus_if.i_scanH = 0; bus_if.i_scanV = 0; bus_if.i_RGB = '0;

    repeat (3) @(negedge clk);
    check("reset o_valid", bus_if.o_valid, 1'b0);
    check("reset o_RGB", bus_if.o_RGB, 24'h0);
    check("reset o_tracking", bus_if.o_tracking, 1'b0);
    check("reset o_trail_count", bus_if.o_trail_count, 5'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    scan("idle pass", 5, 5, 24'h123456, 24'h123456);
    check("idle tracking", bus_if.o_tracking, 1'b0);

    drive_point(100, 200, 1'b0);
    frame();
    check("track after commit", bus_if.o_tracking, 1'b1);
    scan("box right", 108, 200, 24'hA5A5A5, RED);
    scan("box top", 100, 192, 24'hA5A5A5, RED);
    scan("box corner", 92, 208, 24'hA5A5A5, RED);
    scan("box centre", 100, 200, 24'hA5A5A5, 24'hA5A5A5);
    scan("box outside", 109, 200, 24'hA5A5A5, 24'hA5A5A5);
    scan("box past corner", 108, 209, 24'hA5A5A5, 24'hA5A5A5);

    drive_point(3, 3, 1'b0);
    frame();
    scan("edge right", 11, 3, 24'h010203, RED);
    scan("edge bottom", 3, 11, 24'h010203, RED);
    scan("edge no wrap", 630, 3, 24'h010203, 24'h010203);
    scan("edge no wrap2", 635, 11, 24'h010203, 24'h010203);
    scan("trail first", 101, 201, 24'h010203, TRAIL_ON ? GREEN : 24'h010203);
    scan("trail miss", 102, 200, 24'h010203, 24'h010203);

    drive_point(640, 10, 1'b0);
    frame();
    scan("bad point ignored", 11, 3, 24'h0F0F0F, RED);
    check("bad point tracking", bus_if.o_tracking, 1'b1);

    for (int k = 1; k <= 10; k++) begin
      drive_point(10 * k, 50, 1'b0);
      frame();
    end
    check("trail saturate", bus_if.o_trail_count, TRAIL_ON ? 5'd8 : 5'd0);
    scan("trail dot", 21, 51, 24'h333333, TRAIL_ON ? GREEN : 24'h333333);
    scan("trail oldest gone", 10, 50, 24'h333333, 24'h333333);
    scan("trail old pt gone", 3, 3, 24'h333333, 24'h333333);
    scan("box cur", 108, 50, 24'h333333, RED);

    drive_point(200, 100, 1'b0);
    drive_point(300, 300, 1'b1);
    scan("simul commit old", 208, 100, 24'h444444, RED);
    scan("simul new pending", 308, 300, 24'h444444, 24'h444444);
    frame();
    scan("simul later commit", 308, 300, 24'h444444, RED);

    repeat (14) frame();
    check("lost 14 tracking", bus_if.o_tracking, 1'b1);
    frame();
    check("lost 15 tracking", bus_if.o_tracking, 1'b0);
    check("lost 15 trail", bus_if.o_trail_count, 5'd0);
    scan("lost pass", 308, 300, 24'h555555, 24'h555555);

    drive_point(50, 60, 1'b0);
    frame();
    @(negedge clk);
    bus_if.i_scan_valid = 1'b1;
    bus_if.i_scanV      = 10'd60;
    bus_if.i_RGB        = 24'h777777;
    for (int i = 0; i < 4; i++) begin
      bus_if.i_scanH = 10'(55 + i);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst o_valid", bus_if.o_valid, 1'b0);
    check("midrst o_RGB", bus_if.o_RGB, 24'h0);
    check("midrst o_tracking", bus_if.o_tracking, 1'b0);
    check("midrst o_trail_count", bus_if.o_trail_count, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.i_scan_valid = 1'b0;
    repeat (3) @(negedge clk);
    scan("after midrst", 58, 52, 24'h777777, 24'h777777);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/point_overlay.md
# point_overlay

Downstream consumer of the tracker's `o_pointH`/`o_pointV`/`o_valid` result. It keeps the current tracked point and a short history trail, latched at frame boundaries so a frame never tears. It then overlays a box outline around the current point and dots at past points onto the 640x480 VGA pixel stream, ahead of the VGA output stage. It also drops the overlay after the target has been lost for a configurable number of frames.

## Interface
- `TRAIL_DEPTH`, 8: history entries in the ring buffer (power of two, 2..16).
- `BOX_HALF`, 8: half-size of the box outline, in pixels.
- `LOST_FRAMES`, 15: frame starts without a new point before reverting to IDLE (1..255).
- `BOX_COLOR`, 24'hFF0000: RGB of the box outline.
- `TRAIL_COLOR`, 24'h00FF00: RGB of trail dots.
- `i_clk`  in  1  single system clock (25 MHz pixel clock).
- `i_rst`  in  1  synchronous, active-high reset.
- `i_point_valid`  in  1  one-cycle pulse: tracked point on `i_pointH`/`i_pointV` is valid.
- `i_pointH`  in  10  tracked column, 0..639.
- `i_pointV`  in  10  tracked row, 0..479.
- `i_frame_start`  in  1  one-cycle pulse before pixel (0,0) of each VGA frame.
- `i_scan_valid`  in  1  pixel beat valid on `i_scanH`/`i_scanV`/`i_RGB`.
- `i_scanH`  in  10  scan column.
- `i_scanV`  in  10  scan row.
- `i_RGB`  in  24  background pixel, {R,G,B}.
- `o_RGB`  out  24  overlaid pixel.
- `o_valid`  out  1  `o_RGB` valid.
- `o_trail_count`  out  5  number of occupied trail entries, 0..TRAIL_DEPTH.
- `o_tracking`  out  1  high while in the TRACK state.

## Operation
**Point capture**
- On `i_point_valid`, a point with H<640 and V<480 is stored into the pending register and sets `pend_flag`.
- Out-of-range points are discarded.
- If several points arrive in one frame, the last one wins.

**Commit on `i_frame_start`**
- If `pend_flag` is set:
  - the current point is pushed into the trail ring at `wr_ptr`;
  - `wr_ptr` increments modulo TRAIL_DEPTH;
  - the count saturates at TRAIL_DEPTH, after which the oldest entry is overwritten;
  - pending becomes the current point;
  - `pend_flag` clears and `lost_cnt` clears.
- The very first commit after IDLE pushes nothing; the trail starts empty.
- If `pend_flag` is clear: `lost_cnt` increments, saturating at 255.

**Simultaneous `i_point_valid` and `i_frame_start`**
- The commit uses the pending value as it stood before this cycle.
- The new point becomes pending for the next frame.

**FSM**
- IDLE → TRACK: on a commit.
- TRACK → IDLE: at the frame start where `lost_cnt` reaches LOST_FRAMES.
- On entering IDLE: trail count := 0, `wr_ptr` := 0.
- In IDLE the pixel stream passes through unmodified.

**Overlay (TRACK only)**
- Differences are computed as 11-bit signed values: dH = scanH − curH, dV = scanV − curV.
- Box hit: (|dH| == BOX_HALF and |dV| <= BOX_HALF) or (|dV| == BOX_HALF and |dH| <= BOX_HALF).
- Box parts beyond the screen are simply never scanned; there is no wrap-around.
- Trail hit: for any occupied entry, |scanH − tH| <= 1 and |scanV − tV| <= 1 (3x3 dot).
- Priority: box > trail > `i_RGB`.

## Timing
- Overlay pipeline latency is exactly 2 cycles:
  - `o_valid` = `i_scan_valid` delayed 2 cycles;
  - `o_RGB` corresponds to the beat 2 cycles earlier;
  - no backpressure.
- Stage 1 registers `i_RGB`, the box hit and the trail hit (parallel compare across all entries). Stage 2 registers the muxed colour.
- Current point, trail and FSM update on the `i_frame_start` cycle. The first pixel whose stage-1 evaluation occurs after that edge sees the new state.
- `o_trail_count` and `o_tracking` are registered and update one cycle after `i_frame_start`.
- Reset values:
  - `o_RGB` = 0, `o_valid` = 0, `o_trail_count` = 0, `o_tracking` = 0;
  - FSM = IDLE, `pend_flag` = 0, `lost_cnt` = 0, `wr_ptr` = 0.
- `i_rst` mid-frame:
  - clears the pipeline;
  - `o_valid` is 0 on the cycle after the reset edge;
  - beats in flight are discarded.

## Configuration
- `POINT_OVERLAY_TRAIL_EN` defined: the trail ring, trail-hit compare and `o_trail_count` are all built.
- Undefined:
  - no ring storage is synthesized;
  - trail hit is constant 0 and `o_trail_count` is tied to 0;
  - box overlay, FSM and latency are unchanged.

## Test plan
- **Reset, then scan:** reset, then scan (5,5) with RGB 24'h123456 → 2 cycles later `o_valid`=1, `o_RGB`=24'h123456, `o_tracking`=0.
- **Box edges:** point (100,200), frame start, then scan (108,200) and (100,192) → both 24'hFF0000. Scan (100,200) → `i_RGB`. Scan (109,200) → `i_RGB`.
- **Edge point:** point (3,3) → box visible only at H=11 / V=11 edges, no artefacts at H≈630. Point (640,10) → ignored, state unchanged.
- **Trail (TRAIL_EN):** 10 frames with points (10k,50), k=1..10 → `o_trail_count` saturates at 8. Scan (21,51) → 24'h00FF00. The oldest entry (10,50) is overwritten.
- **Lost target:** with LOST_FRAMES=15, stop points → IDLE at the 15th empty frame start, `o_trail_count`=0, pass-through. A simultaneous point + frame start commits only the prior pending point.
- **Mid-frame reset:** assert `i_rst` while `i_scan_valid` is streaming → `o_valid`=0 the next cycle, all outputs at reset values.
